// File: rtl/latency_pattern_tx.sv
// -----------------------------------------------------------------------------
// latency_pattern_tx
//
// Transmit-side pattern generator for GT latency/alignment tests.
// The payload is a free-running 16-bit cycle count, so the receiver can
// subtract what it sees from its own copy of the count to get the latency.
// An IDLE comma word is inserted at a fixed period for RX comma alignment and
// clock correction. A burst of IDLEs is sent on every entry to RUN. One
// payload slot can be replaced by a byte-swapped comma on request, so the
// receiver can be shown detecting a misaligned word.
//
// Ports:
//   usrclk_i      GT TX user clock; all logic runs in this domain
//   rst_i         asynchronous, active-high reset
//   en_i          pattern enable (level)
//   tx_ready_i    GT TX reset done (level)
//   inject_err_i  pulse; corrupt the next payload slot
//   tx_data_o     GT TX data [15:0]
//   tx_k_o        GT TX charisk [1:0]; bit1 = upper byte
//   running_o     high while in RUN
//   sent_cnt_o    payload words sent since reset (saturating)
//   err_cnt_o     corrupted words sent since reset (saturating)
// -----------------------------------------------------------------------------
module latency_pattern_tx #(
    parameter logic [15:0] g_IDLE          = 16'hbc95,
    parameter int unsigned g_IDLE_PERIOD   = 193,
    parameter int unsigned g_STARTUP_IDLES = 16
) (
    input  logic        usrclk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        tx_ready_i,
    input  logic        inject_err_i,
    output logic [15:0] tx_data_o,
    output logic [1:0]  tx_k_o,
    output logic        running_o,
    output logic [31:0] sent_cnt_o,
    output logic [15:0] err_cnt_o
);

    localparam int PER_W = $clog2(g_IDLE_PERIOD);
    localparam int SU_W  = $clog2(g_STARTUP_IDLES + 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(g_IDLE_PERIOD - 1);
    localparam logic [SU_W-1:0]  SU_LAST  = SU_W'(g_STARTUP_IDLES - 1);

    // Comma with its bytes swapped: looks like a byte-misaligned IDLE.
    localparam logic [15:0] BAD_WORD = {g_IDLE[7:0], g_IDLE[15:8]};

    typedef enum logic [1:0] {
        S_WAIT    = 2'd0,
        S_STARTUP = 2'd1,
        S_RUN     = 2'd2
    } state_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hffff_ffff) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hffff) ? v : v + 16'd1;
    endfunction

    state_t             state_q, state_d;
    logic [15:0]        cyc_q, cyc_d;
    logic [PER_W-1:0]   per_q, per_d;
    logic [SU_W-1:0]    su_q, su_d;
    logic               pend_q, pend_d;
    logic [15:0]        data_q, data_d;
    logic [1:0]         k_q, k_d;
    logic [31:0]        sent_q, sent_d;
    logic [15:0]        err_q, err_d;
    logic               go;

    assign go = en_i & tx_ready_i;

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        per_d   = per_q;
        su_d    = su_q;
        pend_d  = pend_q;
        data_d  = g_IDLE;
        k_d     = 2'b10;
        sent_d  = sent_q;
        err_d   = err_q;

        case (state_q)
            S_WAIT: begin
                per_d = '0;
                su_d  = '0;
                if (go) begin
                    state_d = S_STARTUP;
                end
            end

            S_STARTUP: begin
                cyc_d = cyc_q + 16'd1;
                su_d  = su_q + 1'b1;
                if (!go) begin
                    state_d = S_WAIT;
                end else if (su_q == SU_LAST) begin
                    state_d = S_RUN;
                    per_d   = '0;
                end
            end

            S_RUN: begin
                cyc_d = cyc_q + 16'd1;
                per_d = (per_q == PER_LAST) ? '0 : per_q + 1'b1;
                // Slot 0 of each period is the IDLE (already the default);
                // every other slot carries payload or the injected error.
                if (per_q != '0) begin
                    if (pend_q) begin
                        data_d = BAD_WORD;
                        k_d    = 2'b01;
                        pend_d = 1'b0;
                        err_d  = sat_inc16(err_q);
                    end else begin
                        data_d = cyc_q;
                        k_d    = 2'b00;
                        sent_d = sat_inc32(sent_q);
                    end
                end
                // The word for this edge is still a RUN word; IDLE follows.
                if (!go) begin
                    state_d = S_WAIT;
                end
            end

            default: begin
                state_d = S_WAIT;
            end
        endcase

        // A request arriving while one is being consumed re-arms the flag.
        if (inject_err_i) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge usrclk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_WAIT;
            cyc_q   <= '0;
            per_q   <= '0;
            su_q    <= '0;
            pend_q  <= 1'b0;
            data_q  <= g_IDLE;
            k_q     <= 2'b10;
            sent_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            per_q   <= per_d;
            su_q    <= su_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
            k_q     <= k_d;
            sent_q  <= sent_d;
            err_q   <= err_d;
        end
    end

    assign tx_data_o  = data_q;
    assign tx_k_o     = k_q;
    assign running_o  = (state_q == S_RUN);
    assign sent_cnt_o = sent_q;
    assign err_cnt_o  = err_q;

endmodule

// File: doc/latency_pattern_tx.md
Name: latency_pattern_tx

Overview:
- Synthesizable transmit-side pattern generator for the occ_phy GT latency/alignment tests.
- Drives GT TX data/charisk with a free-running cycle count as payload.
- Inserts IDLE comma words at a fixed period for RX comma alignment and clock correction.
- Provides a startup IDLE burst, an error-injection hook and sent-word statistics, so the RX checker can measure TX-to-RX latency and detect byte misalignment.

Parameters:
- g_IDLE, 16'hbc95, IDLE word; comma K28.5 in the upper byte.
- g_IDLE_PERIOD, 193, period of IDLE insertion in RUN, in cycles; must be >= 2.
- g_STARTUP_IDLES, 16, number of consecutive IDLE words sent on entry to RUN before the periodic pattern starts; must be >= 1.

Ports:
- usrclk_i  in  1  GT TX user clock; all logic in this domain.
- rst_i  in  1  asynchronous, active-high reset.
- en_i  in  1  pattern enable, level.
- tx_ready_i  in  1  GT TX reset done, level.
- inject_err_i  in  1  pulse; request one corrupted payload slot.
- tx_data_o  out  16  GT TX data.
- tx_k_o  out  2  GT TX charisk; bit1 = upper byte.
- running_o  out  1  high while in state RUN.
- sent_cnt_o  out  32  payload words sent since last reset; saturating.
- err_cnt_o  out  16  corrupted words sent; saturating.

Behaviour:
- Reset (async assert, sync release) sets:
  - tx_data_o = g_IDLE, tx_k_o = 2'b10, running_o = 0
  - sent_cnt_o = 0, err_cnt_o = 0
  - state = WAIT, cycle count = 0, period count = 0, startup count = 0, pending-error flag = 0
- All outputs are registered. Output in cycle n+1 reflects state and counters at edge n.
- States:
  - WAIT: outputs IDLE every cycle. Goes to STARTUP when en_i=1 and tx_ready_i=1. Clears the period and startup counters.
  - STARTUP: outputs IDLE every cycle and increments the startup count. After g_STARTUP_IDLES IDLEs it goes to RUN with period count = 0.
  - RUN: on each cycle:
    - period count == 0: output IDLE (tx_k_o = 2'b10, tx_data_o = g_IDLE).
    - otherwise: payload slot, tx_k_o = 2'b00, tx_data_o = cycle count[15:0].
    - Period count wraps at g_IDLE_PERIOD-1 back to 0.
  - From STARTUP or RUN: en_i=0 or tx_ready_i=0 sampled means next state is WAIT. The output of that following cycle is already IDLE.
- Cycle count:
  - 16-bit, increments every cycle in STARTUP and RUN, including IDLE slots, so tx minus rx gives latency in cycles.
  - Holds in WAIT. Wraps 16'hffff -> 16'h0000 silently.
- sent_cnt_o increments once per payload slot output and saturates at 32'hffffffff.
- Error injection:
  - inject_err_i=1 on any cycle sets the pending flag; multiple pulses before consumption count as one.
  - The next RUN payload slot is replaced by a misaligned comma: tx_k_o = 2'b01, tx_data_o = {g_IDLE[7:0], g_IDLE[15:8]}.
  - That slot clears the flag, increments err_cnt_o (saturating at 16'hffff), and does not increment sent_cnt_o.
  - The cycle count still advances.
  - The pending flag survives WAIT and STARTUP. It is cleared only by reset or consumption.
  - A pulse in the same cycle that consumes the flag re-arms it for the following payload slot.
- IDLE slots are never corrupted; injection always waits for a payload slot.
- Simultaneous en_i fall and payload slot: the registered output for that edge is still computed as RUN, and the next cycle shows IDLE.

Test Plan:
- Reset then en_i=1, tx_ready_i=1 -> WAIT IDLE for 1 cycle, then 16 IDLEs (STARTUP), running_o=1. The first payload word equals the cycle count at that slot, k=00. IDLE repeats exactly every 193 cycles. Consecutive payloads increment by 1, and by 2 across an IDLE.
- Run 70000 cycles -> payload wraps 16'hffff -> 16'h0000 with no glitch. sent_cnt_o equals the number of k=00 words observed.
- inject_err_i pulse landing on an IDLE slot -> the following slot shows k=01, data=16'h95bc. err_cnt_o=1, sent_cnt_o unchanged for that slot. The next payload equals the corrupted slot's cycle count + 1.
- tx_ready_i drop mid-RUN for 5 cycles -> IDLE-only output and running_o=0 within 1 cycle. On return: 16 startup IDLEs, payload resumes from the held cycle count, sent_cnt_o preserved.
- Async rst_i asserted mid-clock during RUN -> outputs immediately show IDLE/2'b10 and counters 0. After release with en_i=1, the full startup sequence repeats.
- Loopback into the team's RX latency checker with a fixed 7-cycle pipe -> latency_min = latency_max = 7, no fail. One injection -> the checker reports fail.
